// File: rtl/dm_cache_ctrl.sv
// Direct-mapped, one-word-per-line, write-through, no-write-allocate cache
// controller. Owns the valid bits and the hit compare. The tag and data RAMs
// live outside and have a registered read port. Misses and all stores go to a
// single-word request/ready memory port.
module dm_cache_ctrl #(
   parameter int ADDR_BITS  = 32,
   parameter int DATA_BITS  = 32,
   parameter int INDEX_BITS = 5,
   parameter int TAG_BITS   = 25
) (
   input  logic                  Clk_i,
   input  logic                  Rst_n_i,
   // core side
   input  logic                  CoreReq_i,
   input  logic                  CoreWrite_i,
   input  logic [ADDR_BITS-1:0]  CoreAddr_i,
   input  logic [DATA_BITS-1:0]  CoreWData_i,
   output logic                  CoreStall_o,
   output logic [DATA_BITS-1:0]  CoreRData_o,
   output logic                  CoreRValid_o,
   // tag RAM
   output logic [INDEX_BITS-1:0] TagAddress_o,
   output logic [TAG_BITS-1:0]   TagIn_o,
   output logic                  TagWrite_o,
   input  logic [TAG_BITS-1:0]   TagOut_i,
   // data RAM
   output logic [INDEX_BITS-1:0] DataAddress_o,
   output logic [DATA_BITS-1:0]  DataIn_o,
   output logic                  DataWrite_o,
   input  logic [DATA_BITS-1:0]  DataOut_i,
   // memory side
   output logic                  MemReq_o,
   output logic                  MemWrite_o,
   output logic [ADDR_BITS-1:0]  MemAddr_o,
   output logic [DATA_BITS-1:0]  MemWData_o,
   input  logic [DATA_BITS-1:0]  MemRData_i,
   input  logic                  MemReady_i
);

   localparam int CACHE_LINES = 2 ** INDEX_BITS;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      LOOKUP = 2'd1,
      MEM_RD = 2'd2,
      MEM_WR = 2'd3
   } state_t;

   state_t                 state_q;
   logic [TAG_BITS-1:0]    tag_q;
   logic [INDEX_BITS-1:0]  idx_q;
   logic                   write_q;
   logic [DATA_BITS-1:0]   wdata_q;
   logic [CACHE_LINES-1:0] valid_q;

   logic                   mem_req_q;
   logic                   mem_write_q;
   logic [ADDR_BITS-1:0]   mem_addr_q;
   logic [DATA_BITS-1:0]   mem_wdata_q;

   logic [INDEX_BITS-1:0]  core_idx;
   logic [TAG_BITS-1:0]    core_tag;
   logic                   hit;
   logic                   load_hit;
   logic                   store_hit;
   logic                   refill_done;

   // Byte offset bits of the core address carry no information for a word cache.
   logic                   unused_byte_bits;
   assign unused_byte_bits = ^CoreAddr_i[1:0];

   assign core_idx = CoreAddr_i[INDEX_BITS+1:2];
   assign core_tag = CoreAddr_i[ADDR_BITS-1:INDEX_BITS+2];

   // TagOut/DataOut were read on the accepting edge, so they are valid in LOOKUP.
   assign hit         = valid_q[idx_q] && (TagOut_i == tag_q);
   assign load_hit    = (state_q == LOOKUP) && !write_q && hit;
   assign store_hit   = (state_q == LOOKUP) &&  write_q && hit;
   assign refill_done = (state_q == MEM_RD) && MemReady_i;

   // In IDLE the RAM address follows the core so the read fires on the accept edge.
   assign TagAddress_o  = (state_q == IDLE) ? core_idx : idx_q;
   assign DataAddress_o = TagAddress_o;

   // RAM write port: refill writes tag+data, a store hit updates data only.
   assign TagWrite_o  = refill_done;
   assign TagIn_o     = tag_q;
   assign DataWrite_o = refill_done || store_hit;
   assign DataIn_o    = refill_done ? MemRData_i : wdata_q;

   // Load data is returned straight from the RAM on a hit or from memory on a refill.
   assign CoreStall_o  = (state_q != IDLE);
   assign CoreRValid_o = load_hit || refill_done;
   assign CoreRData_o  = refill_done ? MemRData_i :
                         load_hit    ? DataOut_i  : '0;

   assign MemReq_o   = mem_req_q;
   assign MemWrite_o = mem_write_q;
   assign MemAddr_o  = mem_addr_q;
   assign MemWData_o = mem_wdata_q;

   // Controller FSM with the request latch, valid bits and registered memory port.
   always_ff @(posedge Clk_i) begin
      if (!Rst_n_i) begin
         state_q     <= IDLE;
         tag_q       <= '0;
         idx_q       <= '0;
         write_q     <= 1'b0;
         wdata_q     <= '0;
         valid_q     <= '0;
         mem_req_q   <= 1'b0;
         mem_write_q <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (CoreReq_i) begin
                  tag_q   <= core_tag;
                  idx_q   <= core_idx;
                  write_q <= CoreWrite_i;
                  wdata_q <= CoreWData_i;
                  state_q <= LOOKUP;
               end
            end
            LOOKUP: begin
               if (!write_q && hit) begin
                  state_q <= IDLE;
               end else begin
                  // Loads that miss refill; every store is written through.
                  mem_req_q   <= 1'b1;
                  mem_write_q <= write_q;
                  mem_addr_q  <= {tag_q, idx_q, 2'b00};
                  mem_wdata_q <= write_q ? wdata_q : '0;
                  state_q     <= write_q ? MEM_WR : MEM_RD;
               end
            end
            MEM_RD: begin
               if (MemReady_i) begin
                  valid_q[idx_q] <= 1'b1;
                  mem_req_q      <= 1'b0;
                  mem_write_q    <= 1'b0;
                  mem_addr_q     <= '0;
                  mem_wdata_q    <= '0;
                  state_q        <= IDLE;
               end
            end
            MEM_WR: begin
               if (MemReady_i) begin
                  mem_req_q   <= 1'b0;
                  mem_write_q <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wdata_q <= '0;
                  state_q     <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Bench for dm_cache_ctrl: models the tag/data RAMs and a memory slave, and
// predicts every transaction from a line-level model of the cache contents.
module tb_dm_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        core_req, core_write;
   logic [31:0] core_addr, core_wdata;
   logic        core_stall, core_rvalid;
   logic [31:0] core_rdata;
   logic [4:0]  tag_addr, data_addr;
   logic [24:0] tag_in, tag_out;
   logic        tag_write, data_write;
   logic [31:0] data_in, data_out;
   logic        mem_req, mem_write, mem_ready;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   int checks = 0;
   int errors = 0;
   int txn_no = 0;

   // Behavioural RAMs: writes land on the negedge, reads are registered.
   logic [24:0] tag_ram  [32];
   logic [31:0] data_ram [32];

   // Memory contents seen by the slave and by the reference model.
   logic [31:0] env_mem [logic [31:0]];
   logic [31:0] ref_mem [logic [31:0]];

   // Reference cache: which word each line holds.
   bit          m_valid [32];
   logic [24:0] m_tag   [32];
   logic [31:0] m_data  [32];

   always #5 clk = ~clk;

   dm_cache_ctrl dut (
      .Clk_i        (clk),
      .Rst_n_i      (rst_n),
      .CoreReq_i    (core_req),
      .CoreWrite_i  (core_write),
      .CoreAddr_i   (core_addr),
      .CoreWData_i  (core_wdata),
      .CoreStall_o  (core_stall),
      .CoreRData_o  (core_rdata),
      .CoreRValid_o (core_rvalid),
      .TagAddress_o (tag_addr),
      .TagIn_o      (tag_in),
      .TagWrite_o   (tag_write),
      .TagOut_i     (tag_out),
      .DataAddress_o(data_addr),
      .DataIn_o     (data_in),
      .DataWrite_o  (data_write),
      .DataOut_i    (data_out),
      .MemReq_o     (mem_req),
      .MemWrite_o   (mem_write),
      .MemAddr_o    (mem_addr),
      .MemWData_o   (mem_wdata),
      .MemRData_i   (mem_rdata),
      .MemReady_i   (mem_ready)
   );

   always @(negedge clk) begin
      if (tag_write)  tag_ram[tag_addr]   = tag_in;
      if (data_write) data_ram[data_addr] = data_in;
   end

   always @(posedge clk) begin
      tag_out  <= tag_ram[tag_addr];
      data_out <= data_ram[data_addr];
   end

   function automatic logic [31:0] def_val(input logic [31:0] a);
      return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
   endfunction

   function automatic logic [31:0] env_get(input logic [31:0] a);
      if (env_mem.exists(a)) return env_mem[a];
      return def_val(a);
   endfunction

   function automatic logic [31:0] ref_get(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return def_val(a);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One core transaction: predict from the model, drive it, serve memory, compare.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input int wait_cyc);
      logic [4:0]  idx;
      logic [24:0] tag;
      logic [31:0] wa, exp_data, rdata;
      bit          exp_hit, exp_mem, done;
      int          exp_busy, exp_tw, exp_dw;
      int          busy, rv_cnt, rv_cyc, req_cnt, tw_cnt, dw_cnt, port_bad;

      idx = addr[6:2];
      tag = addr[31:7];
      wa  = {addr[31:2], 2'b00};
      exp_hit  = m_valid[idx] && (m_tag[idx] == tag);
      exp_mem  = wr || !exp_hit;
      exp_busy = exp_mem ? (2 + wait_cyc) : 1;
      exp_tw   = (!wr && !exp_hit) ? 1 : 0;
      exp_dw   = ((!wr && !exp_hit) || (wr && exp_hit)) ? 1 : 0;
      exp_data = exp_hit ? m_data[idx] : ref_get(wa);
      if (wr) begin
         ref_mem[wa] = wdata;
         if (exp_hit) m_data[idx] = wdata;
      end else if (!exp_hit) begin
         m_valid[idx] = 1'b1;
         m_tag[idx]   = tag;
         m_data[idx]  = exp_data;
      end

      chk("idle_stall", core_stall, 1'b0);
      core_req   = 1'b1;
      core_write = wr;
      core_addr  = addr;
      core_wdata = wdata;
      busy = 0; rv_cnt = 0; rv_cyc = 0; req_cnt = 0; tw_cnt = 0; dw_cnt = 0; port_bad = 0;
      rdata = '0;
      done = 1'b0;
      @(posedge clk);
      for (int c = 0; c < 40 && !done; c++) begin
         #1;
         core_req = 1'b0;
         if (mem_req) begin
            req_cnt++;
            if (mem_addr !== wa || mem_write !== wr || (wr && mem_wdata !== wdata)) port_bad++;
            if (req_cnt > wait_cyc) begin
               mem_ready = 1'b1;
               mem_rdata = env_get(mem_addr);
               if (mem_write) env_mem[mem_addr] = mem_wdata;
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
         end else begin
            mem_ready = 1'b0;
         end
         #1;
         if (!core_stall) begin
            done = 1'b1;
         end else begin
            busy++;
            if (tag_write)  tw_cnt++;
            if (data_write) dw_cnt++;
            if (core_rvalid) begin
               rv_cnt++;
               rv_cyc = busy;
               rdata  = core_rdata;
            end
         end
         if (!done) @(posedge clk);
      end
      mem_ready = 1'b0;

      chk("completed", done, 1'b1);
      chk("busy_cycles", busy, exp_busy);
      chk("mem_req_cycles", req_cnt, exp_mem ? wait_cyc + 1 : 0);
      chk("mem_port_stable", port_bad, 0);
      chk("tag_writes", tw_cnt, exp_tw);
      chk("data_writes", dw_cnt, exp_dw);
      chk("rvalid_count", rv_cnt, wr ? 0 : 1);
      if (!wr) begin
         chk("rvalid_cycle", rv_cyc, exp_busy);
         chk("load_data", rdata, exp_data);
      end
      chk("idle_mem_req", mem_req, 1'b0);
      chk("idle_writes", {tag_write, data_write, core_rvalid}, 3'b000);
      $display("txn %0d %s addr=%h wdata=%h wait=%0d exp_hit=%0b rdata=%h busy=%0d",
               txn_no, wr ? "ST" : "LD", addr, wdata, wait_cyc, exp_hit, rdata, busy);
      txn_no++;
   endtask

   initial begin
      rst_n = 1'b0;
      core_req = 1'b0; core_write = 1'b0; core_addr = '0; core_wdata = '0;
      mem_ready = 1'b0; mem_rdata = '0;
      for (int i = 0; i < 32; i++) begin
         m_valid[i] = 1'b0;
         m_tag[i]   = '0;
         m_data[i]  = '0;
      end
      env_mem[32'h0000_0040] = 32'hDEAD_BEEF;
      ref_mem[32'h0000_0040] = 32'hDEAD_BEEF;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_stall", core_stall, 1'b0);
      chk("rst_rvalid", core_rvalid, 1'b0);
      chk("rst_rdata", core_rdata, 32'h0);
      chk("rst_mem_req", {mem_req, mem_write}, 2'b00);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_ram_we", {tag_write, data_write}, 2'b00);
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      // Miss with 3 wait cycles, then hit
      run_txn(1'b0, 32'h0000_0040, 32'h0, 3);
      run_txn(1'b0, 32'h0000_0040, 32'h0, 3);
      // Store hit then load hit
      run_txn(1'b1, 32'h0000_0040, 32'h1234_5678, 2);
      run_txn(1'b0, 32'h0000_0040, 32'h0, 1);
      // Store miss (no allocate), then load misses
      run_txn(1'b1, 32'h0000_0080, 32'hCAFE_F00D, 1);
      run_txn(1'b0, 32'h0000_0080, 32'h0, 2);
      // Tag alias on idx 16
      run_txn(1'b0, 32'h0000_0040, 32'h0, 0);
      run_txn(1'b0, 32'h0000_1040, 32'h0, 2);
      run_txn(1'b0, 32'h0000_0040, 32'h0, 1);
      // Index corners with zero-wait refill, then immediate repeat
      run_txn(1'b0, 32'h0000_2000, 32'h0, 0);
      run_txn(1'b0, 32'h0000_2000, 32'h0, 0);
      run_txn(1'b0, 32'h0000_307C, 32'h0, 0);
      run_txn(1'b0, 32'h0000_307C, 32'h0, 0);

      // Reset while waiting in MEM_RD
      core_req = 1'b1; core_write = 1'b0; core_addr = 32'h0000_5044; core_wdata = '0;
      @(posedge clk);
      #1;
      core_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_pre_req", mem_req, 1'b1);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("abort_mem_req", mem_req, 1'b0);
      chk("abort_stall", core_stall, 1'b0);
      chk("abort_mem_addr", mem_addr, 32'h0);
      rst_n = 1'b1;
      for (int i = 0; i < 32; i++) m_valid[i] = 1'b0;
      $display("txn %0d RESET during MEM_RD addr=00005044", txn_no);
      txn_no++;
      #1;
      run_txn(1'b0, 32'h0000_307C, 32'h0, 1);
      run_txn(1'b0, 32'h0000_307C, 32'h0, 0);

      // Randomized traffic over a small set of lines and aliasing tags
      for (int n = 0; n < 60; n++) begin
         logic [31:0] a;
         a = ({30'h0, 2'($urandom_range(0, 2))} << 7) | ({27'h0, 5'($urandom_range(0, 7))} << 2)
             | {30'h0, 2'($urandom_range(0, 3))};
         run_txn($urandom_range(0, 2) == 0, a, $urandom, $urandom_range(0, 3));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/dm_cache_ctrl.md
Name: dm_cache_ctrl

Overview:
- Controller for a direct-mapped, one-word-per-line, write-through, no-write-allocate cache.
- Sits directly upstream of the tag RAM and the matching data RAM. Drives their address, write-data and write-enable; consumes their registered read outputs.
- Holds the per-line valid bits and performs the hit compare.
- On the downstream side, drives a single-word request/ready memory port.

Parameters:
- ADDR_BITS, 32, core/memory byte-address width.
- DATA_BITS, 32, word width.
- INDEX_BITS, 5, line index width; CACHE_LINES = 2**INDEX_BITS.
- TAG_BITS, 25, tag width; must equal ADDR_BITS-INDEX_BITS-2.

Ports:
- Clk  in  1  clock; all logic on posedge, except that RAM writes land on the following negedge.
- Rst_n  in  1  synchronous active-low reset.
- CoreReq  in  1  request valid; sampled only in IDLE.
- CoreWrite  in  1  1=store, 0=load.
- CoreAddr  in  ADDR_BITS  byte address; bits [1:0] ignored.
- CoreWData  in  DATA_BITS  store data.
- CoreStall  out  1  high while a request is in flight.
- CoreRData  out  DATA_BITS  load data.
- CoreRValid  out  1  one-cycle pulse qualifying CoreRData.
- TagAddress  out  INDEX_BITS  tag RAM index.
- TagIn  out  TAG_BITS  tag RAM write data.
- TagWrite  out  1  tag RAM write enable.
- TagOut  in  TAG_BITS  tag RAM read data; registered, valid the cycle after the address is presented.
- DataAddress  out  INDEX_BITS  data RAM index; always equal to TagAddress.
- DataIn  out  DATA_BITS  data RAM write data.
- DataWrite  out  1  data RAM write enable.
- DataOut  in  DATA_BITS  data RAM read data; same timing as TagOut.
- MemReq  out  1  memory request.
- MemWrite  out  1  memory write flag.
- MemAddr  out  ADDR_BITS  word-aligned memory address.
- MemWData  out  DATA_BITS  memory write data.
- MemRData  in  DATA_BITS  memory read data; valid with MemReady.
- MemReady  in  1  memory completion.

Behaviour:
- Address split:
  - idx = Addr[INDEX_BITS+1:2]
  - tag = Addr[ADDR_BITS-1:INDEX_BITS+2]
  - MemAddr = {tag, idx, 2'b00}
- Reset (Rst_n=0 at posedge):
  - state=IDLE; all CACHE_LINES valid bits cleared.
  - All registered outputs and outputs of IDLE are 0: CoreStall, CoreRValid, CoreRData, MemReq, MemWrite, MemAddr, MemWData, TagWrite, DataWrite.
  - Reset mid-transaction abandons it; MemReq drops the cycle after reset is sampled.
  - RAM contents are not cleared.
- TagAddress/DataAddress mux:
  - In IDLE: idx of CoreAddr (combinational), so the RAM read fires on the accepting edge.
  - In all other states: idx of the latched address.
- FSM states: IDLE, LOOKUP, MEM_RD, MEM_WR.
- IDLE:
  - CoreStall=0.
  - CoreReq=1 -> latch CoreAddr, CoreWrite, CoreWData; go to LOOKUP.
- LOOKUP (CoreStall=1):
  - hit = valid[idx] && (TagOut == latched tag).
  - Load hit: CoreRData=DataOut, CoreRValid=1 this cycle; go to IDLE. Latency: accept edge + 1 cycle.
  - Load miss: go to MEM_RD.
  - Store hit: DataWrite=1, DataIn=latched data; go to MEM_WR.
  - Store miss: no RAM write, valid bit unchanged; go to MEM_WR.
- MEM_RD (CoreStall=1):
  - MemReq=1, MemWrite=0; hold until MemReady.
  - MemReady may arrive in the first MEM_RD cycle (zero wait).
  - In the MemReady cycle:
    - TagWrite=1, TagIn=latched tag.
    - DataWrite=1, DataIn=MemRData.
    - valid[idx] set at the posedge.
    - CoreRData=MemRData, CoreRValid=1.
    - Go to IDLE.
- MEM_WR (CoreStall=1):
  - MemReq=1, MemWrite=1, MemWData=latched data.
  - On MemReady go to IDLE; no CoreRValid.
- MemReq, MemWrite, MemAddr and MemWData are stable from MemReq rise until MemReady is sampled.
- CoreReq while CoreStall=1 is ignored; the core holds its request.
- A new request is accepted in the first IDLE cycle after completion, so back-to-back requests are allowed.
- Same-line back-to-back: a refill in cycle N (RAM write at negedge N) is seen by a lookup presented at posedge N+1.
- Tag alias (same idx, different tag): treated as a miss; the refill overwrites the line.
- idx 0 and idx CACHE_LINES-1 behave identically to all other lines.
- TagWrite and DataWrite are never asserted in IDLE.

Test Plan:
- Reset, then load 0x0000_0040 with memory returning 0xDEAD_BEEF after 3 wait cycles:
  - miss; MemReq high 4 cycles at MemAddr 0x40;
  - CoreRValid with 0xDEADBEEF in the MemReady cycle;
  - same load repeated is a hit with CoreRValid 1 cycle after accept and MemReq never raised.
- Store 0x1234_5678 to 0x40 (hit):
  - DataWrite pulse in LOOKUP; MemReq/MemWrite to 0x40 until MemReady;
  - a following load of 0x40 hits and returns 0x12345678.
- Store to uncached 0x0000_0080:
  - MemWrite issued; TagWrite and DataWrite never asserted;
  - a following load of 0x80 misses.
- Alias: load 0x0000_0040, then 0x0000_1040 (same idx, tag differs):
  - second access misses and refills;
  - load of 0x40 then misses again.
- Index corners (idx 0 and 31) with a zero-wait MemReady (high in the first MEM_RD cycle):
  - refill completes in one MEM_RD cycle;
  - an immediate repeat hits.
- Assert Rst_n=0 while in MEM_RD waiting on MemReady:
  - MemReq drops next cycle, state IDLE, CoreStall=0;
  - a subsequent load of a previously cached line misses (valid bits cleared).
